// File: rtl/multi_delta_counter.sv
// Bank of independent up/down delta counters with wrap or saturate arithmetic,
// overflow/underflow flags (sticky or pulse) and per-channel threshold compare.
module multi_delta_counter #(
  parameter int unsigned NUM_CNT  = 4,
  parameter int unsigned WIDTH    = 8,
  parameter logic        SATURATE = 1'b0,
  parameter logic        STICKY   = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_CNT-1:0]         clear_i,
  input  logic [NUM_CNT-1:0]         load_i,
  input  logic [NUM_CNT*WIDTH-1:0]   d_i,
  input  logic [NUM_CNT-1:0]         en_i,
  input  logic [NUM_CNT-1:0]         down_i,
  input  logic [NUM_CNT*WIDTH-1:0]   delta_i,
  input  logic [NUM_CNT*WIDTH-1:0]   thresh_i,
  output logic [NUM_CNT*WIDTH-1:0]   q_o,
  output logic [NUM_CNT-1:0]         overflow_o,
  output logic [NUM_CNT-1:0]         underflow_o,
  output logic [NUM_CNT-1:0]         thresh_hit_o,
  output logic                       any_flag_o
);

  logic [WIDTH-1:0]   cnt_q [NUM_CNT];
  logic [WIDTH-1:0]   cnt_d [NUM_CNT];
  logic [NUM_CNT-1:0] ovf_q, ovf_d;
  logic [NUM_CNT-1:0] udf_q, udf_d;

  logic [WIDTH-1:0] cur, dlt;
  logic [WIDTH:0]   sum, diff;
  logic             ev_o, ev_u;

  always_comb begin
    ovf_d = '0;
    udf_d = '0;
    cur   = '0;
    dlt   = '0;
    sum   = '0;
    diff  = '0;
    ev_o  = 1'b0;
    ev_u  = 1'b0;
    for (int unsigned c = 0; c < NUM_CNT; c++) begin
      cur  = cnt_q[c];
      dlt  = delta_i[c*WIDTH +: WIDTH];
      sum  = {1'b0, cur} + {1'b0, dlt};
      // Borrow out of the (WIDTH+1)-bit difference is exactly delta > q.
      diff = {1'b0, cur} - {1'b0, dlt};
      ev_o = en_i[c] & ~down_i[c] & sum[WIDTH];
      ev_u = en_i[c] &  down_i[c] & diff[WIDTH];
      cnt_d[c] = cur;
      if (clear_i[c]) begin
        cnt_d[c] = '0;
        ovf_d[c] = 1'b0;
        udf_d[c] = 1'b0;
      end else if (load_i[c]) begin
        cnt_d[c] = d_i[c*WIDTH +: WIDTH];
        ovf_d[c] = 1'b0;
        udf_d[c] = 1'b0;
      end else begin
        if (en_i[c]) begin
          if (down_i[c]) cnt_d[c] = (SATURATE && ev_u) ? '0 : diff[WIDTH-1:0];
          else           cnt_d[c] = (SATURATE && ev_o) ? '1 : sum[WIDTH-1:0];
        end
        ovf_d[c] = ev_o | (STICKY & ovf_q[c]);
        udf_d[c] = ev_u | (STICKY & udf_q[c]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < NUM_CNT; c++) cnt_q[c] <= '0;
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CNT; c++) cnt_q[c] <= cnt_d[c];
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  always_comb begin
    q_o          = '0;
    thresh_hit_o = '0;
    for (int unsigned c = 0; c < NUM_CNT; c++) begin
      q_o[c*WIDTH +: WIDTH] = cnt_q[c];
      thresh_hit_o[c]       = (cnt_q[c] >= thresh_i[c*WIDTH +: WIDTH]);
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;
  assign any_flag_o  = |{ovf_q, udf_q};

endmodule

// File: tb/tb_multi_delta_counter.sv
// Bench for multi_delta_counter: a wrap/sticky and a saturate/pulse instance
// share stimulus and are checked against an integer reference model.
module tb_multi_delta_counter;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] clear, load, en, down;
  logic [N*W-1:0] d, delta, thresh;

  logic [N*W-1:0] q_w, q_s;
  logic [N-1:0]   ov_w, un_w, th_w, ov_s, un_s, th_s;
  logic           any_w, any_s;

  int total = 0;
  int bad   = 0;

  // Reference model: index 0 = wrap/sticky, 1 = saturate/pulse
  int mq  [2][N];
  bit mov [2][N];
  bit mun [2][N];

  always #5 clk = ~clk;

  multi_delta_counter #(.NUM_CNT(N), .WIDTH(W), .SATURATE(1'b0), .STICKY(1'b1)) dut_w (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .load_i(load), .d_i(d),
    .en_i(en), .down_i(down), .delta_i(delta), .thresh_i(thresh),
    .q_o(q_w), .overflow_o(ov_w), .underflow_o(un_w), .thresh_hit_o(th_w),
    .any_flag_o(any_w));

  multi_delta_counter #(.NUM_CNT(N), .WIDTH(W), .SATURATE(1'b1), .STICKY(1'b0)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .load_i(load), .d_i(d),
    .en_i(en), .down_i(down), .delta_i(delta), .thresh_i(thresh),
    .q_o(q_s), .overflow_o(ov_s), .underflow_o(un_s), .thresh_hit_o(th_s),
    .any_flag_o(any_s));

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < N; c++) begin
        int dl;
        bit eo, eu;
        dl = int'(delta[c*W +: W]);
        eo = 0;
        eu = 0;
        if (!rst_n) begin
          mq[k][c] = 0; mov[k][c] = 0; mun[k][c] = 0;
        end else if (clear[c]) begin
          mq[k][c] = 0; mov[k][c] = 0; mun[k][c] = 0;
        end else if (load[c]) begin
          mq[k][c] = int'(d[c*W +: W]); mov[k][c] = 0; mun[k][c] = 0;
        end else begin
          if (en[c]) begin
            if (down[c]) begin
              if (dl > mq[k][c]) begin
                eu = 1;
                mq[k][c] = (k == 1) ? 0 : mq[k][c] - dl + 256;
              end else mq[k][c] = mq[k][c] - dl;
            end else begin
              if (mq[k][c] + dl > 255) begin
                eo = 1;
                mq[k][c] = (k == 1) ? 255 : mq[k][c] + dl - 256;
              end else mq[k][c] = mq[k][c] + dl;
            end
          end
          if (k == 0) begin
            mov[k][c] = mov[k][c] | eo;
            mun[k][c] = mun[k][c] | eu;
          end else begin
            mov[k][c] = eo;
            mun[k][c] = eu;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    clear = '0; load = '0; en = '0; down = '0;
  endtask

  task automatic test_reset();
    idle();
    d = '0; delta = '0; thresh = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (q_w !== '0) begin bad++; $display("FAIL reset_q_w got %h exp 0", q_w); end
    total++; if (q_s !== '0) begin bad++; $display("FAIL reset_q_s got %h exp 0", q_s); end
    total++; if ({ov_w, un_w, ov_s, un_s} !== '0) begin bad++; $display("FAIL reset_flags got %b exp 0", {ov_w, un_w, ov_s, un_s}); end
    total++; if ({any_w, any_s} !== 2'b00) begin bad++; $display("FAIL reset_any got %b exp 00", {any_w, any_s}); end
    total++; if (th_w !== 4'hF) begin bad++; $display("FAIL reset_thresh0 got %b exp 1111", th_w); end
    thresh = 32'h01_10_FF_02;
    #1;
    total++; if (th_s !== 4'h0) begin bad++; $display("FAIL reset_thresh_nz got %b exp 0000", th_s); end
    thresh = '0;
  endtask

  task automatic test_wrap_overflow();
    idle();
    load = 4'hF; d = {8'd33, 8'd77, 8'd120, 8'd250};
    tick();
    idle();
    en[0] = 1'b1; delta[7:0] = 8'd10;
    tick();
    idle();
    total++; if (q_w[7:0] !== 8'd4) begin bad++; $display("FAIL wrap_q got %0d exp 4", q_w[7:0]); end
    total++; if (ov_w[0] !== 1'b1) begin bad++; $display("FAIL wrap_ovf got %b exp 1", ov_w[0]); end
    total++; if (q_w[31:8] !== {8'd33, 8'd77, 8'd120}) begin bad++; $display("FAIL wrap_others got %h exp 214d78", q_w[31:8]); end
    total++; if (q_s[7:0] !== 8'hFF) begin bad++; $display("FAIL sat_ovf_q got %h exp ff", q_s[7:0]); end
    total++; if (ov_s !== 4'b0001) begin bad++; $display("FAIL pulse_ovf_set got %b exp 0001", ov_s); end
    tick();
    total++; if (ov_s[0] !== 1'b0) begin bad++; $display("FAIL pulse_ovf_clear got %b exp 0", ov_s[0]); end
    total++; if (ov_w[0] !== 1'b1 || any_w !== 1'b1) begin bad++; $display("FAIL sticky_hold got %b/%b exp 1/1", ov_w[0], any_w); end
    total++; if (any_s !== 1'b0) begin bad++; $display("FAIL pulse_any got %b exp 0", any_s); end
  endtask

  task automatic test_clear_wins();
    idle();
    clear[0] = 1'b1; en[0] = 1'b1; delta[7:0] = 8'd255;
    tick();
    idle();
    total++; if (q_w[7:0] !== 8'd0 || ov_w[0] !== 1'b0) begin bad++; $display("FAIL clear_wins got q=%0d ovf=%b exp 0/0", q_w[7:0], ov_w[0]); end
    en[0] = 1'b1; delta[7:0] = 8'd200;
    tick(); tick();
    idle();
    load[0] = 1'b1; d[7:0] = 8'h55; en[0] = 1'b1; delta[7:0] = 8'd250;
    tick();
    idle();
    total++; if (q_w[7:0] !== 8'h55 || ov_w[0] !== 1'b0) begin bad++; $display("FAIL load_wins got q=%h ovf=%b exp 55/0", q_w[7:0], ov_w[0]); end
  endtask

  task automatic test_sat_underflow();
    idle();
    load[1] = 1'b1; d[15:8] = 8'd3;
    tick();
    idle();
    en[1] = 1'b1; down[1] = 1'b1; delta[15:8] = 8'd5;
    tick();
    total++; if (q_s[15:8] !== 8'd0 || un_s[1] !== 1'b1) begin bad++; $display("FAIL sat_udf got q=%0d udf=%b exp 0/1", q_s[15:8], un_s[1]); end
    total++; if (q_w[15:8] !== 8'd254 || un_w[1] !== 1'b1) begin bad++; $display("FAIL wrap_udf got q=%0d udf=%b exp 254/1", q_w[15:8], un_w[1]); end
    tick();
    idle();
    total++; if (q_s[15:8] !== 8'd0 || un_s[1] !== 1'b1) begin bad++; $display("FAIL sat_udf_rep got q=%0d udf=%b exp 0/1", q_s[15:8], un_s[1]); end
    total++; if (q_w[15:8] !== 8'd249 || un_w[1] !== 1'b1) begin bad++; $display("FAIL wrap_udf_rep got q=%0d udf=%b exp 249/1", q_w[15:8], un_w[1]); end
    total++; if (ov_s[1] !== 1'b0 || ov_w[1] !== 1'b0) begin bad++; $display("FAIL udf_no_ovf got %b/%b exp 0/0", ov_s[1], ov_w[1]); end
  endtask

  task automatic test_pulse_load();
    idle();
    load[2] = 1'b1; d[23:16] = 8'hF0;
    tick();
    idle();
    en[2] = 1'b1; delta[23:16] = 8'h20;
    tick();
    idle();
    total++; if (ov_s[2] !== 1'b1 || q_s[23:16] !== 8'hFF) begin bad++; $display("FAIL pulse_evt got ovf=%b q=%h exp 1/ff", ov_s[2], q_s[23:16]); end
    load[2] = 1'b1; d[23:16] = 8'h80;
    tick();
    idle();
    total++; if (q_s[23:16] !== 8'h80 || q_w[23:16] !== 8'h80) begin bad++; $display("FAIL load80 got %h/%h exp 80/80", q_s[23:16], q_w[23:16]); end
    total++; if ({ov_s[2], un_s[2], ov_w[2], un_w[2]} !== 4'b0) begin bad++; $display("FAIL load_flags got %b exp 0000", {ov_s[2], un_s[2], ov_w[2], un_w[2]}); end
  endtask

  task automatic test_boundaries();
    idle();
    load = 4'b0011; d[7:0] = 8'd250; d[15:8] = 8'd5;
    tick();
    idle();
    en = 4'b0111; down = 4'b0010;
    delta[7:0] = 8'd5; delta[15:8] = 8'd5; delta[23:16] = 8'd0;
    tick();
    idle();
    total++; if (q_w[23:0] !== {8'h80, 8'd0, 8'd255}) begin bad++; $display("FAIL exact_land_w got %h exp 8000ff", q_w[23:0]); end
    total++; if (q_s[23:0] !== {8'h80, 8'd0, 8'd255}) begin bad++; $display("FAIL exact_land_s got %h exp 8000ff", q_s[23:0]); end
    total++; if ({ov_w[2:0], un_w[2:0], ov_s[2:0], un_s[2:0]} !== '0) begin bad++; $display("FAIL exact_land_flags got %b exp 0", {ov_w[2:0], un_w[2:0], ov_s[2:0], un_s[2:0]}); end
  endtask

  task automatic test_threshold();
    idle();
    clear[3] = 1'b1;
    thresh[31:24] = 8'd16;
    tick();
    idle();
    total++; if (th_w[3] !== 1'b0) begin bad++; $display("FAIL thresh_start got %b exp 0", th_w[3]); end
    en[3] = 1'b1; delta[31:24] = 8'd4;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (q_w[31:24] !== 8'(4*k) || th_w[3] !== (k >= 4) || th_s[3] !== (k >= 4)) begin
        bad++;
        $display("FAIL thresh_step%0d got q=%0d hit=%b/%b exp q=%0d hit=%b", k, q_w[31:24], th_w[3], th_s[3], 4*k, (k >= 4));
      end
    end
    idle();
    thresh[31:24] = 8'd25;
    #1;
    total++; if (th_w[3] !== 1'b0) begin bad++; $display("FAIL thresh_live got %b exp 0", th_w[3]); end
  endtask

  task automatic test_reset_mid();
    en = '1; down = 4'b0101; delta = $urandom; clear = '0; load = '0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    total++; if (q_w !== '0 || q_s !== '0) begin bad++; $display("FAIL reset_mid_q got %h/%h exp 0/0", q_w, q_s); end
    total++; if ({ov_w, un_w, ov_s, un_s, any_w, any_s} !== '0) begin bad++; $display("FAIL reset_mid_flags got %b exp 0", {ov_w, un_w, ov_s, un_s, any_w, any_s}); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      rst_n = ($urandom_range(63) != 0);
      for (int c = 0; c < N; c++) begin
        clear[c] = ($urandom_range(15) == 0);
        load[c]  = ($urandom_range(7) == 0);
        en[c]    = $urandom_range(1);
        down[c]  = $urandom_range(1);
        d[c*W +: W]      = 8'($urandom);
        delta[c*W +: W]  = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(8));
        thresh[c*W +: W] = 8'($urandom);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        logic [N*W-1:0] gq;
        logic [N-1:0] gov, gun, gth;
        logic gany;
        bit eany;
        gq   = (k == 0) ? q_w : q_s;
        gov  = (k == 0) ? ov_w : ov_s;
        gun  = (k == 0) ? un_w : un_s;
        gth  = (k == 0) ? th_w : th_s;
        gany = (k == 0) ? any_w : any_s;
        eany = 0;
        for (int c = 0; c < N; c++) begin
          eany = eany | mov[k][c] | mun[k][c];
          total++;
          if (gq[c*W +: W] !== 8'(mq[k][c]) || gov[c] !== mov[k][c] || gun[c] !== mun[k][c] ||
              gth[c] !== (mq[k][c] >= int'(thresh[c*W +: W]))) begin
            bad++;
            $display("FAIL rand it%0d cfg%0d ch%0d got q=%0d o=%b u=%b t=%b exp q=%0d o=%b u=%b t=%b",
                     it, k, c, gq[c*W +: W], gov[c], gun[c], gth[c], mq[k][c], mov[k][c], mun[k][c],
                     (mq[k][c] >= int'(thresh[c*W +: W])));
          end
        end
        total++;
        if (gany !== eany) begin bad++; $display("FAIL rand_any it%0d cfg%0d got %b exp %b", it, k, gany, eany); end
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    d = '0; delta = '0; thresh = '0;
    @(negedge clk);
    test_reset();
    test_wrap_overflow();
    test_clear_wins();
    test_sat_underflow();
    test_pulse_load();
    test_boundaries();
    test_threshold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
